// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Pops bytes from the UART transmit FIFO and shifts each one out as an
//   8N1 frame (8N2 when STOP_BITS=2): a start bit, then data LSB first,
//   then stop bit(s). Frames run back to back with no gap while the FIFO
//   stays non-empty. The line idles high.
//
// Ports
//   clk_i      system clock, rising edge
//   reset_i    synchronous active-high reset
//   data       FIFO head byte, valid while have_next=1
//   have_next  FIFO non-empty
//   next       one-cycle pop strobe (combinational)
//   tx         serial line (registered)
//   busy       high whenever a frame is in progress
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] data,
    input  logic       have_next,
    output logic       next,
    output logic       tx,
    output logic       busy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;      // data bit index in DATA, stop bit index in STOP
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          bit_end, frame_end, pop;

    assign bit_end   = (baud_q == BAUD_LAST);
    assign frame_end = (state_q == S_STOP) && bit_end && (bit_q == STOP_LAST);
    // Pop either from idle or on the very last stop cycle, so the next start
    // bit follows immediately.
    assign pop       = !reset_i && have_next && ((state_q == S_IDLE) || frame_end);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        if (pop) begin
            state_d = S_START;
            baud_d  = '0;
            bit_d   = '0;
            shreg_d = data;
        end else if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
            if (bit_end) begin
                case (state_q)
                    S_START: begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                    S_DATA: begin
                        shreg_d = {1'b0, shreg_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_d = S_STOP;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                    S_STOP: begin
                        if (bit_q == STOP_LAST) begin
                            state_d = S_IDLE;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // tx is registered from the next-state values so the start bit appears
    // on the first cycle after the pop edge with no extra pipeline stage.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    assign next = pop;
    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE);

endmodule
